// File: rtl/serdes_pkg.sv
// Shared types and helpers for the serializer/deserializer link blocks.
// Contents: FSM state enum, the level driven on the line when idle, and the
//           bit-counter width helper.
package serdes_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_e;

   // Level of ser_out whenever no frame bit is being driven; also used as the
   // fill bit shifted into the vacated end of the shift register.
   localparam logic IDLE_LEVEL = 1'b0;

   // Width of a counter that spans 0..width-1 (never narrower than one bit).
   function automatic int cnt_width(input int width);
      return (width < 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// Word-load handshake and serial output bundle of the PISO serializer.
// master: word producer that also observes the line; slave: the serializer.
// Signals: load_data/load_valid/load_ready, ser_out/ser_valid/ser_first/ser_last.
interface piso_serializer_if #(
   parameter int WIDTH = 8
);

   logic [WIDTH-1:0] load_data;
   logic             load_valid;
   logic             load_ready;
   logic             ser_out;
   logic             ser_valid;
   logic             ser_first;
   logic             ser_last;

   modport master (
      output load_data,
      output load_valid,
      input  load_ready,
      input  ser_out,
      input  ser_valid,
      input  ser_first,
      input  ser_last
   );

   modport slave (
      input  load_data,
      input  load_valid,
      output load_ready,
      output ser_out,
      output ser_valid,
      output ser_first,
      output ser_last
   );

endinterface

// File: rtl/piso_serializer_bit_counter.sv
// Modulo-WIDTH up-counter tracking the position of the current frame bit.
// Ports: clk, reset_n (async, active-low), clear / load_zero / en (synchronous,
//        in that priority), count (registered), tc (count == WIDTH-1).
module piso_serializer_bit_counter
   import serdes_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CW    = cnt_width(WIDTH)
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          clear,
   input  logic          load_zero,
   input  logic          en,
   output logic [CW-1:0] count,
   output logic          tc
);

   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clear || load_zero) begin
         count_d = '0;
      end else if (en) begin
         // Wrap explicitly so non-power-of-two widths never exceed WIDTH-1.
         count_d = (count_q == LAST) ? '0 : count_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;
   assign tc    = (count_q == LAST);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter: takes a WIDTH-bit word on a valid/ready
// handshake and shifts it out one bit per ser_en strobe with first/last markers.
// Ports: clk, reset_n (async, active-low), clear (sync abort), ser_en (bit
//        strobe), bus (slave: load_* in/ready out, ser_* out). Latency: one
//        cycle from accept to first bit; back-to-back words leave no idle gap.
module piso_serializer
   import serdes_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              clear,
   input  logic              ser_en,
   piso_serializer_if.slave  bus
);

   localparam int CW = cnt_width(WIDTH);
   // Count value of the second-to-last bit: advancing from it lands on the
   // last bit, so ser_last is raised on that transition.
   localparam logic [CW-1:0] PENULT = CW'(WIDTH - 2);

   state_e           state_q,  state_d;
   logic [WIDTH-1:0] shreg_q,  shreg_d;
   logic             valid_q,  valid_d;
   logic             first_q,  first_d;
   logic             last_q,   last_d;

   logic [CW-1:0]    count;
   logic             tc;
   logic             load_ready;
   logic             accept;
   logic             advance;

   // Ready never looks at load_valid, so a producer may wait on it safely.
   assign load_ready = !clear && ((state_q == IDLE) || (tc && ser_en));
   assign accept     = bus.load_valid && load_ready;
   assign advance    = (state_q == SHIFT) && ser_en;

   piso_serializer_bit_counter #(
      .WIDTH (WIDTH),
      .CW    (CW)
   ) u_bit_counter (
      .clk       (clk),
      .reset_n   (reset_n),
      .clear     (clear),
      .load_zero (accept),
      .en        (advance),
      .count     (count),
      .tc        (tc)
   );

   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      valid_d = valid_q;
      first_d = first_q;
      last_d  = last_q;

      if (clear) begin
         state_d = IDLE;
         shreg_d = {WIDTH{IDLE_LEVEL}};
         valid_d = 1'b0;
         first_d = 1'b0;
         last_d  = 1'b0;
      end else if (accept) begin
         // Covers both a load from IDLE and the back-to-back load on the
         // final enabled bit of the previous frame.
         state_d = SHIFT;
         shreg_d = bus.load_data;
         valid_d = 1'b1;
         first_d = 1'b1;
         last_d  = 1'b0;
      end else if (advance) begin
         if (tc) begin
            state_d = IDLE;
            shreg_d = {WIDTH{IDLE_LEVEL}};
            valid_d = 1'b0;
            first_d = 1'b0;
            last_d  = 1'b0;
         end else begin
            // The outgoing bit always sits at the serial end of the register.
            if (MSB_FIRST) begin
               shreg_d = {shreg_q[WIDTH-2:0], IDLE_LEVEL};
            end else begin
               shreg_d = {IDLE_LEVEL, shreg_q[WIDTH-1:1]};
            end
            first_d = 1'b0;
            last_d  = (count == PENULT);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         shreg_q <= '0;
         valid_q <= 1'b0;
         first_q <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         valid_q <= valid_d;
         first_q <= first_d;
         last_q  <= last_d;
      end
   end

   // Idle clears the shift register, so the serial end reads IDLE_LEVEL then.
   assign bus.ser_out    = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
   assign bus.ser_valid  = valid_q;
   assign bus.ser_first  = first_q;
   assign bus.ser_last   = last_q;
   assign bus.load_ready = load_ready;

endmodule

// File: tb/tb_piso_serializer.sv
module tb_piso_serializer;

   logic clk;
   logic reset_n;
   logic clear;
   logic ser_en;

   piso_serializer_if #(.WIDTH(8)) ifa ();
   piso_serializer_if #(.WIDTH(8)) ifb ();
   piso_serializer_if #(.WIDTH(2)) ifc ();

   piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_a (
      .clk(clk), .reset_n(reset_n), .clear(clear), .ser_en(ser_en), .bus(ifa.slave));
   piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_b (
      .clk(clk), .reset_n(reset_n), .clear(clear), .ser_en(ser_en), .bus(ifb.slave));
   piso_serializer #(.WIDTH(2), .MSB_FIRST(1'b1)) u_c (
      .clk(clk), .reset_n(reset_n), .clear(clear), .ser_en(ser_en), .bus(ifc.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [2:0] obs_ready, obs_out, obs_valid, obs_first, obs_last;
   assign obs_ready = {ifc.load_ready, ifb.load_ready, ifa.load_ready};
   assign obs_out   = {ifc.ser_out,    ifb.ser_out,    ifa.ser_out};
   assign obs_valid = {ifc.ser_valid,  ifb.ser_valid,  ifa.ser_valid};
   assign obs_first = {ifc.ser_first,  ifb.ser_first,  ifa.ser_first};
   assign obs_last  = {ifc.ser_last,   ifb.ser_last,   ifa.ser_last};

   int checks = 0;
   int errors = 0;

   // Reference model: per instance, whether a frame is on the line, the word
   // being sent and which bit position (0 = first sent) is currently shown.
   int          m_w   [3] = '{8, 8, 2};
   bit          m_msb [3] = '{1'b1, 1'b0, 1'b1};
   bit          m_busy[3];
   logic [31:0] m_word[3];
   int          m_idx [3];

   logic [15:0] hist_a, hist_b;
   int          vcnt_c, rdy_a, vcnt_a;

   task automatic chk(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   task automatic chk_int(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 3; d++) begin
         m_busy[d] = 1'b0;
         m_word[d] = '0;
         m_idx[d]  = 0;
      end
   endtask

   // One clock: drive inputs, check every instance against the model, then
   // advance the model as the edge is taken.
   task automatic step(input bit lv, input logic [7:0] data, input bit en, input bit clr);
      bit   exp_rdy[3];
      logic exp_out;
      ifa.load_valid = lv; ifb.load_valid = lv; ifc.load_valid = lv;
      ifa.load_data  = data; ifb.load_data = data; ifc.load_data = data[1:0];
      ser_en = en;
      clear  = clr;
      #1;
      for (int d = 0; d < 3; d++) begin
         exp_rdy[d] = !clr && (!m_busy[d] || (m_idx[d] == m_w[d] - 1 && en));
         if (m_busy[d]) begin
            exp_out = m_msb[d] ? m_word[d][m_w[d] - 1 - m_idx[d]] : m_word[d][m_idx[d]];
         end else begin
            exp_out = 1'b0;
         end
         chk($sformatf("ready[%0d]", d), obs_ready[d], exp_rdy[d]);
         chk($sformatf("ser_out[%0d]", d), obs_out[d], exp_out);
         chk($sformatf("ser_valid[%0d]", d), obs_valid[d], m_busy[d]);
         chk($sformatf("ser_first[%0d]", d), obs_first[d], m_busy[d] && m_idx[d] == 0);
         chk($sformatf("ser_last[%0d]", d), obs_last[d], m_busy[d] && m_idx[d] == m_w[d] - 1);
      end
      hist_a = {hist_a[14:0], obs_out[0]};
      hist_b = {hist_b[14:0], obs_out[1]};
      vcnt_c += int'(obs_valid[2]);
      vcnt_a += int'(obs_valid[0]);
      rdy_a  += int'(obs_ready[0]);
      for (int d = 0; d < 3; d++) begin
         if (!reset_n || clr) begin
            m_busy[d] = 1'b0;
            m_idx[d]  = 0;
         end else if (lv && exp_rdy[d]) begin
            m_busy[d] = 1'b1;
            m_word[d] = 32'(data) & ((32'd1 << m_w[d]) - 32'd1);
            m_idx[d]  = 0;
         end else if (m_busy[d] && en) begin
            if (m_idx[d] == m_w[d] - 1) begin
               m_busy[d] = 1'b0;
               m_idx[d]  = 0;
            end else begin
               m_idx[d]++;
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic settle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
   endtask

   initial begin
      reset_n = 1'b0;
      clear   = 1'b0;
      ser_en  = 1'b0;
      ifa.load_valid = 1'b0; ifb.load_valid = 1'b0; ifc.load_valid = 1'b0;
      ifa.load_data  = '0;   ifb.load_data  = '0;   ifc.load_data  = '0;
      hist_a = '0; hist_b = '0; vcnt_c = 0; vcnt_a = 0; rdy_a = 0;
      model_reset();

      // Reset state, including an offered word that must be ignored.
      step(1'b1, 8'hA5, 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      reset_n = 1'b1;
      settle(2);

      // Asynchronous reset in the middle of a frame.
      step(1'b1, 8'hA5, 1'b1, 1'b0);
      settle(3);
      reset_n = 1'b0;
      #1;
      chk("arst_valid", obs_valid[0], 1'b0);
      chk("arst_out", obs_out[0], 1'b0);
      chk("arst_ready", obs_ready[0], 1'b1);
      model_reset();
      step(1'b0, 8'h00, 1'b1, 1'b0);
      reset_n = 1'b1;
      settle(2);

      // MSB-first A5 with ser_en held high.
      step(1'b1, 8'hA5, 1'b1, 1'b0);
      hist_a = '0;
      settle(8);
      chk_int("a5_msb_bits", int'(hist_a[7:0]), 32'hA5);
      settle(2);

      // LSB-first 01 then 80 back-to-back with load_valid held.
      step(1'b1, 8'h01, 1'b1, 1'b0);
      hist_b = '0;
      for (int i = 0; i < 8; i++) step(1'b1, 8'h80, 1'b1, 1'b0);
      settle(8);
      chk_int("b2b_lsb_bits", int'(hist_b), 32'h8001);
      settle(4);

      // ser_en every third cycle: each bit held three clocks.
      step(1'b1, 8'hC3, 1'b1, 1'b0);
      vcnt_a = 0; rdy_a = 0;
      for (int i = 0; i < 24; i++) step(1'b0, 8'h00, (i % 3) == 2, 1'b0);
      chk_int("slow_frame_len", vcnt_a, 24);
      chk_int("slow_ready_cnt", rdy_a, 1);
      settle(3);

      // Clear at bit 4 of FF while a new word is offered.
      step(1'b1, 8'hFF, 1'b1, 1'b0);
      settle(4);
      step(1'b1, 8'h11, 1'b1, 1'b1);
      chk("clr_valid", obs_valid[0], 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      settle(2);

      // WIDTH=2: 2'b10 twice back-to-back.
      settle(8);
      vcnt_c = 0;
      for (int i = 0; i < 3; i++) step(1'b1, 8'h02, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
      chk_int("w2_valid_cnt", vcnt_c, 4);

      // Randomized traffic against the model.
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 3) != 0,
              $urandom_range(0, 31) == 0);
      end
      settle(10);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
